// File: rtl/decodifica_hamming.sv
// decodifica_hamming: two-stage pipelined Hamming(15,11) decoder with single-error correction.
//
// Codeword layout: Hamming position k (1..15) sits at entrada[15-k].
//   Parity bits: p1 = bit 14, p2 = bit 13, p4 = bit 11, p8 = bit 7.
//   Data bits:   {bit 12, bits 10:8, bits 6:0} form saida[10:0].
//
// Pipeline:
//   S1 registers the raw codeword and its syndrome.
//   S2 registers the corrected data, the syndrome and the correction flag.
//   The whole pipe stalls when the output holds a word that is not being taken.
//
// Optional feature, macro HAMMING_STATS_EN:
//   When defined, two saturating counters track delivered words and delivered
//   corrected words. limpa_contadores clears both, and the clear wins over an
//   increment in the same cycle. When undefined, cnt_* read 0 and
//   limpa_contadores is ignored.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   entrada           received 15-bit codeword
//   entrada_valid     entrada holds a word
//   entrada_ready     block accepts entrada this cycle
//   saida             corrected 11-bit data word
//   sindrome          {s8,s4,s2,s1} of the delivered word
//   corrigido         sindrome != 0; one bit was flipped
//   saida_valid       saida/sindrome/corrigido are valid
//   saida_ready       downstream accepts
//   limpa_contadores  synchronous clear of the statistics counters
//   cnt_palavras      words delivered (saturating)
//   cnt_corrigidos    corrected words delivered (saturating)

module decodifica_hamming #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [14:0]      entrada,
  input  logic             entrada_valid,
  output logic             entrada_ready,
  output logic [10:0]      saida,
  output logic [3:0]       sindrome,
  output logic             corrigido,
  output logic             saida_valid,
  input  logic             saida_ready,
  input  logic             limpa_contadores,
  output logic [CNT_W-1:0] cnt_palavras,
  output logic [CNT_W-1:0] cnt_corrigidos
);

  // Each mask selects the codeword bits whose Hamming position has the
  // corresponding index bit set (parity bit included).
  localparam logic [14:0] MaskS1 = 15'h5555;
  localparam logic [14:0] MaskS2 = 15'h3333;
  localparam logic [14:0] MaskS4 = 15'h0F0F;
  localparam logic [14:0] MaskS8 = 15'h00FF;

  logic        avanca;

  logic [3:0]  sind_d;
  logic        s1_valid_q;
  logic [14:0] s1_word_q;
  logic [3:0]  s1_sind_q;

  logic [14:0] flip;
  logic [14:0] corr_word;
  logic [10:0] saida_d;
  logic        corr_d;

  logic        s2_valid_q;
  logic [10:0] saida_q;
  logic [3:0]  sind_q;
  logic        corr_q;

  // Whole-pipe stall: every stage advances only when the output slot is free
  // or being drained this cycle.
  assign avanca        = !s2_valid_q || saida_ready;
  assign entrada_ready = avanca;

  always_comb begin
    sind_d    = {^(entrada & MaskS8), ^(entrada & MaskS4),
                 ^(entrada & MaskS2), ^(entrada & MaskS1)};
  end

  always_comb begin
    flip = 15'd0;
    if (s1_sind_q != 4'd0) begin
      // Position s lives at bit 15-s.
      flip = 15'd1 << (4'd15 - s1_sind_q);
    end
    corr_word = s1_word_q ^ flip;
    saida_d   = {corr_word[12], corr_word[10:8], corr_word[6:0]};
    corr_d    = (s1_sind_q != 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= 15'd0;
      s1_sind_q  <= 4'd0;
      s2_valid_q <= 1'b0;
      saida_q    <= 11'd0;
      sind_q     <= 4'd0;
      corr_q     <= 1'b0;
    end else if (avanca) begin
      s1_valid_q <= entrada_valid;
      s1_word_q  <= entrada;
      s1_sind_q  <= sind_d;
      s2_valid_q <= s1_valid_q;
      saida_q    <= saida_d;
      sind_q     <= s1_sind_q;
      corr_q     <= corr_d;
    end
  end

  assign saida       = saida_q;
  assign sindrome    = sind_q;
  assign corrigido   = corr_q;
  assign saida_valid = s2_valid_q;

`ifdef HAMMING_STATS_EN
  logic             entrega;
  logic [CNT_W-1:0] cnt_pal_q;
  logic [CNT_W-1:0] cnt_cor_q;

  assign entrega = s2_valid_q && saida_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_pal_q <= '0;
      cnt_cor_q <= '0;
    end else if (limpa_contadores) begin
      cnt_pal_q <= '0;
      cnt_cor_q <= '0;
    end else if (entrega) begin
      if (cnt_pal_q != '1) begin
        cnt_pal_q <= cnt_pal_q + CNT_W'(1);
      end
      if (corr_q && (cnt_cor_q != '1)) begin
        cnt_cor_q <= cnt_cor_q + CNT_W'(1);
      end
    end
  end

  assign cnt_palavras   = cnt_pal_q;
  assign cnt_corrigidos = cnt_cor_q;
`else
  logic unused_limpa;
  assign unused_limpa   = limpa_contadores;
  assign cnt_palavras   = '0;
  assign cnt_corrigidos = '0;
`endif

endmodule

// File: tb/tb_decodifica_hamming.sv
// Testbench for decodifica_hamming: directed vectors, a stall scenario, randomized
// traffic with random backpressure, reset with words in flight and, when
// HAMMING_STATS_EN is defined, counter saturation and clear.

module tb_decodifica_hamming;

  localparam int unsigned CNT_W = 2;
  localparam int CntMax = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [14:0]      entrada;
  logic             entrada_valid;
  logic             entrada_ready;
  logic [10:0]      saida;
  logic [3:0]       sindrome;
  logic             corrigido;
  logic             saida_valid;
  logic             saida_ready;
  logic             limpa_contadores;
  logic [CNT_W-1:0] cnt_palavras;
  logic [CNT_W-1:0] cnt_corrigidos;

  decodifica_hamming #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .entrada          (entrada),
    .entrada_valid    (entrada_valid),
    .entrada_ready    (entrada_ready),
    .saida            (saida),
    .sindrome         (sindrome),
    .corrigido        (corrigido),
    .saida_valid      (saida_valid),
    .saida_ready      (saida_ready),
    .limpa_contadores (limpa_contadores),
    .cnt_palavras     (cnt_palavras),
    .cnt_corrigidos   (cnt_corrigidos)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] d;
    logic [3:0]  s;
    logic        c;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  bit   rand_bp  = 1'b0;
  int   m_pal    = 0;
  int   m_cor    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Build a codeword from data using the positional parity rules.
  function automatic logic [14:0] encode(input logic [10:0] d);
    logic [14:0] c;
    logic        p;
    c       = '0;
    c[12]   = d[10];
    c[10:8] = d[9:7];
    c[6:0]  = d[6:0];
    for (int j = 0; j < 4; j++) begin
      p = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        if ((k & (1 << j)) != 0) p = p ^ c[15-k];
      end
      c[15-(1<<j)] = p;
    end
    return c;
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_pal = 0;
      m_cor = 0;
    end else begin
      check("entrada_ready_rule", 32'(entrada_ready), 32'(!saida_valid || saida_ready));
      check("cnt_palavras", 32'(cnt_palavras), 32'(m_pal));
      check("cnt_corrigidos", 32'(cnt_corrigidos), 32'(m_cor));
      if (saida_valid) begin
        if (q.size() == 0) begin
          check("spurious_output", 32'(1), 32'(0));
        end else begin
          mon_e = q[0];
          check("saida", 32'(saida), 32'(mon_e.d));
          check("sindrome", 32'(sindrome), 32'(mon_e.s));
          check("corrigido", 32'(corrigido), 32'(mon_e.c));
          if (saida_ready) begin
            void'(q.pop_front());
`ifdef HAMMING_STATS_EN
            if (!limpa_contadores) begin
              if (m_pal < CntMax) m_pal++;
              if (mon_e.c && m_cor < CntMax) m_cor++;
            end
`endif
          end
        end
      end
`ifdef HAMMING_STATS_EN
      if (limpa_contadores) begin
        m_pal = 0;
        m_cor = 0;
      end
`endif
    end
  end

  task automatic bp_step();
    if (rand_bp) saida_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bp_step();
    end
  endtask

  // Present one word; returns #1 after the edge that accepted it.
  task automatic send(input logic [14:0] w, input exp_t e);
    bit hs;
    int n;
    entrada       = w;
    entrada_valid = 1'b1;
    hs            = 1'b0;
    n             = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = entrada_ready;
      @(posedge clk);
      #1;
      n++;
      bp_step();
    end
    entrada_valid = 1'b0;
    if (!hs) check("send_timeout", 32'(0), 32'(1));
    else q.push_back(e);
  endtask

  task automatic directed(input logic [14:0] w, input logic [10:0] d, input logic [3:0] s,
                          input logic c);
    exp_t e;
    e = '{d: d, s: s, c: c};
    send(w, e);
    check("lat_edge1_valid", 32'(saida_valid), 32'(0));
    @(posedge clk);
    #1;
    check("lat_edge2_valid", 32'(saida_valid), 32'(1));
    check("dir_saida", 32'(saida), 32'(d));
    check("dir_sindrome", 32'(sindrome), 32'(s));
    check("dir_corrigido", 32'(corrigido), 32'(c));
    @(posedge clk);
    #1;
  endtask

  task automatic random_word(input int emin);
    logic [10:0] d;
    int          e;
    logic [14:0] w;
    exp_t        x;
    d = 11'($urandom);
    e = $urandom_range(emin, 15);
    w = encode(d) ^ ((e == 0) ? 15'd0 : (15'd1 << (15 - e)));
    x = '{d: d, s: 4'(e), c: (e != 0)};
    send(w, x);
  endtask

  task automatic drain(input string tag);
    saida_ready = 1'b1;
    idle(10);
    check(tag, 32'(q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    entrada          = '0;
    entrada_valid    = 1'b0;
    saida_ready      = 1'b1;
    limpa_contadores = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_saida_valid", 32'(saida_valid), 32'(0));
    check("rst_entrada_ready", 32'(entrada_ready), 32'(1));
    check("rst_saida", 32'(saida), 32'(0));
    check("rst_cnt_palavras", 32'(cnt_palavras), 32'(0));
    rst = 1'b0;
    idle(2);

    directed(15'h0000, 11'h000, 4'd0, 1'b0);
    directed(15'h6FFF, 11'h7FF, 4'd3, 1'b1);
    directed(15'h6880, 11'h001, 4'd15, 1'b1);
    directed(15'h7F7F, 11'h7FF, 4'd8, 1'b1);

    // Four back-to-back words with a 3-cycle output stall mid-stream.
    fork
      begin
        for (int i = 0; i < 4; i++) random_word(0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        saida_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_entrada_ready", 32'(entrada_ready), 32'(0));
          check("stall_saida_valid", 32'(saida_valid), 32'(1));
        end
        @(posedge clk);
        #1;
        saida_ready = 1'b1;
      end
    join
    drain("stall_drain_empty");

    // Randomized traffic with random gaps and backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      random_word(0);
    end
    rand_bp = 1'b0;
    drain("random_drain_empty");

`ifdef HAMMING_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 5; i++) random_word(1);
    drain("stats_drain_empty");
    check("sat_cnt_palavras", 32'(cnt_palavras), 32'(3));
    check("sat_cnt_corrigidos", 32'(cnt_corrigidos), 32'(3));
    random_word(1);
    @(posedge clk);
    #1;
    check("clr_word_valid", 32'(saida_valid), 32'(1));
    limpa_contadores = 1'b1;
    @(posedge clk);
    #1;
    limpa_contadores = 1'b0;
    check("clr_cnt_palavras", 32'(cnt_palavras), 32'(0));
    check("clr_cnt_corrigidos", 32'(cnt_corrigidos), 32'(0));
    idle(2);
`else
    check("nostats_cnt_palavras", 32'(cnt_palavras), 32'(0));
    check("nostats_cnt_corrigidos", 32'(cnt_corrigidos), 32'(0));
`endif

    // Reset with two words in flight.
    random_word(0);
    random_word(0);
    rst = 1'b1;
    #1;
    check("rst_fly_saida_valid", 32'(saida_valid), 32'(0));
    check("rst_fly_saida", 32'(saida), 32'(0));
    check("rst_fly_sindrome", 32'(sindrome), 32'(0));
    check("rst_fly_corrigido", 32'(corrigido), 32'(0));
    check("rst_fly_entrada_ready", 32'(entrada_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    check("rst_fly_no_stale", 32'(saida_valid), 32'(0));
    check("rst_fly_queue_empty", 32'(q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
